// File: rtl/lab2_g14_tt_scanner_if.sv
// lab2_g14_tt_scanner_if: control, function-block and result signals of the truth-table scanner
interface lab2_g14_tt_scanner_if #(parameter int N_IN = 4);
    logic              start;
    logic              abort;
    logic [2**N_IN-1:0] expected;
    logic              fn_y;
    logic [N_IN-1:0]   fn_in;
    logic              busy;
    logic              done;
    logic [2**N_IN-1:0] table_q;
    logic [2**N_IN-1:0] mism_q;
    logic [N_IN:0]     err_cnt;
    modport master (
        output start, abort, expected, fn_y,
        input  fn_in, busy, done, table_q, mism_q, err_cnt
    );
    modport slave (
        input  start, abort, expected, fn_y,
        output fn_in, busy, done, table_q, mism_q, err_cnt
    );
endinterface

// File: rtl/lab2_g14_tt_scanner.sv
// lab2_g14_tt_scanner: steps a combinational block through every input vector and checks its truth table
module lab2_g14_tt_scanner #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input logic                   clk,
    input logic                   reset,
    lab2_g14_tt_scanner_if.slave  s
);
    localparam int M  = 2**N_IN;
    localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE} state_t;
    state_t          r_state, w_next;
    logic [N_IN-1:0] r_idx, w_idx_n, r_fn_in;
    logic [CW-1:0]   r_cnt;
    logic [M-1:0]    r_tab, r_mism;
    logic [N_IN:0]   r_err;
    logic            r_done, w_last, w_miss, w_busy;

    assign w_last = r_idx == '1;
    assign w_miss = s.fn_y ^ s.expected[r_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = ST_IDLE;
        case (r_state)
            ST_IDLE:   w_next = (s.start && !s.abort) ? ST_SETTLE : ST_IDLE;
            ST_SETTLE: w_next = s.abort ? ST_IDLE : (r_cnt == '0) ? ST_SAMPLE : ST_SETTLE;
            ST_SAMPLE: w_next = s.abort ? ST_IDLE : w_last ? ST_DONE : ST_SETTLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy  = r_state == ST_SETTLE || r_state == ST_SAMPLE;
        w_idx_n = (r_state == ST_IDLE) ? '0 :
                  (r_state == ST_SAMPLE && w_next == ST_SETTLE) ? r_idx + N_IN'(1) : r_idx;
    end

    // fn_in is registered from the post-edge index so it only moves on the SAMPLE->SETTLE edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx   <= '0;
            r_fn_in <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_tab   <= '0;
            r_mism  <= '0;
            r_err   <= '0;
        end else begin
            r_idx   <= w_idx_n;
            r_fn_in <= (w_next == ST_SETTLE || w_next == ST_SAMPLE) ? w_idx_n : '0;
            r_done  <= w_next == ST_DONE;
            r_cnt   <= (w_next == ST_SETTLE && r_state != ST_SETTLE) ? CW'(SETTLE - 1) :
                       (r_state == ST_SETTLE && r_cnt != '0) ? r_cnt - CW'(1) : r_cnt;
            if (r_state == ST_IDLE && w_next == ST_SETTLE) begin
                r_tab  <= '0;
                r_mism <= '0;
                r_err  <= '0;
            end else if (r_state == ST_SAMPLE && !s.abort) begin
                r_tab[r_idx]  <= s.fn_y;
                r_mism[r_idx] <= w_miss;
                r_err         <= r_err + (N_IN+1)'(w_miss);
            end
        end
    end

    assign s.fn_in   = r_fn_in;
    assign s.busy    = w_busy;
    assign s.done    = r_done;
    assign s.table_q = r_tab;
    assign s.mism_q  = r_mism;
    assign s.err_cnt = r_err;
endmodule

// File: tb/tb_lab2_g14_tt_scanner.sv
// tb_lab2_g14_tt_scanner: vector-table and random scans against a truth-table model, plus abort/reset sequences
module tb_lab2_g14_tt_scanner;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] r_tab;
    int          n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    lab2_g14_tt_scanner_if #(.N_IN(4)) a ();
    lab2_g14_tt_scanner_if #(.N_IN(4)) b ();

    lab2_g14_tt_scanner #(.N_IN(4), .SETTLE(1)) u_dut1 (.clk(clk), .reset(reset), .s(a));
    lab2_g14_tt_scanner #(.N_IN(4), .SETTLE(3)) u_dut3 (.clk(clk), .reset(reset), .s(b));

    // the function block under test is just a truth table indexed by the applied vector
    assign a.fn_y = r_tab[a.fn_in];
    assign b.fn_y = r_tab[b.fn_in];

    typedef struct {
        bit          w;
        bit          poke;
        logic [15:0] tab;
        logic [15:0] exp;
        logic [15:0] tq;
        logic [15:0] mq;
        logic [4:0]  ec;
    } vec_t;
    vec_t v[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    function automatic vec_t model(input bit w, input logic [15:0] tab, input logic [15:0] exp);
        vec_t r;
        r.w = w; r.poke = 1'b0; r.tab = tab; r.exp = exp;
        r.tq = tab;
        r.mq = tab ^ exp;
        r.ec = 5'($countones(tab ^ exp));
        return r;
    endfunction

    task automatic scan(input vec_t t);
        int s = t.w ? 3 : 1;
        int last = 16 * (s + 1);
        int bad_fn = 0, bad_busy = 0, ndone = 0, done_at = -1;
        logic [3:0] fi;
        logic bs, dn;
        @(negedge clk);
        r_tab = t.tab;
        a.expected = t.exp;
        b.expected = t.exp;
        if (t.w) b.start = 1'b1; else a.start = 1'b1;
        for (int k = 0; k <= last + 3; k++) begin
            @(negedge clk);
            if (k == 0) begin a.start = 1'b0; b.start = 1'b0; end
            if (t.poke && (k == 9 || k == last)) a.start = 1'b1;
            if (t.poke && (k == 10 || k == last + 1)) a.start = 1'b0;
            fi = t.w ? b.fn_in : a.fn_in;
            bs = t.w ? b.busy : a.busy;
            dn = t.w ? b.done : a.done;
            if (fi !== (k < last ? 4'(k / (s + 1)) : 4'd0)) bad_fn++;
            if (bs !== (k < last)) bad_busy++;
            if (dn === 1'b1) begin ndone++; done_at = k; end
        end
        chk("fn_in sequence", bad_fn, 0);
        chk("busy window", bad_busy, 0);
        chk("done edge", done_at, last);
        chk("done count", ndone, 1);
        chk("table_q", t.w ? b.table_q : a.table_q, t.tq);
        chk("mism_q", t.w ? b.mism_q : a.mism_q, t.mq);
        chk("err_cnt", t.w ? b.err_cnt : a.err_cnt, t.ec);
    endtask

    initial begin
        int nd;
        logic busy9, busy10;
        v[0] = '{w: 0, poke: 0, tab: 16'hF000, exp: 16'hF000, tq: 16'hF000, mq: 16'h0000, ec: 5'd0};
        v[1] = '{w: 0, poke: 0, tab: 16'h69B6, exp: 16'h6996, tq: 16'h69B6, mq: 16'h0020, ec: 5'd1};
        v[2] = '{w: 0, poke: 0, tab: 16'h0000, exp: 16'hFFFF, tq: 16'h0000, mq: 16'hFFFF, ec: 5'd16};
        v[3] = '{w: 1, poke: 0, tab: 16'hF000, exp: 16'h0F0F, tq: 16'hF000, mq: 16'hFF0F, ec: 5'd12};
        v[4] = '{w: 0, poke: 1, tab: 16'hA5A5, exp: 16'h5A5A, tq: 16'hA5A5, mq: 16'hFFFF, ec: 5'd16};
        for (int i = 5; i < 14; i++) v[i] = model(i % 4 == 3, 16'($urandom), 16'($urandom));

        reset = 1'b1;
        r_tab = '0;
        a.start = 0; a.abort = 0; a.expected = '0;
        b.start = 0; b.abort = 0; b.expected = '0;
        repeat (2) @(negedge clk);
        chk("reset fn_in", a.fn_in, 0);
        chk("reset busy", a.busy, 0);
        chk("reset done", a.done, 0);
        chk("reset table_q", a.table_q, 0);
        chk("reset err_cnt", b.err_cnt, 0);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) scan(v[i]);

        // abort seen in SAMPLE of vector 4 must drop that sample and the done pulse
        nd = 0;
        @(negedge clk);
        r_tab = 16'hFFFF;
        a.expected = 16'h00F0;
        a.start = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            if (k == 0) a.start = 1'b0;
            if (k == 9) begin busy9 = a.busy; a.abort = 1'b1; end
            if (k == 10) busy10 = a.busy;
            if (k == 12) a.start = 1'b1;
            if (k > 10 && a.busy !== 1'b0) nd++;
            if (a.done === 1'b1) nd++;
        end
        a.start = 1'b0;
        a.abort = 1'b0;
        chk("abort busy before", busy9, 1);
        chk("abort busy after", busy10, 0);
        chk("abort no done/no start", nd, 0);
        chk("abort table_q", a.table_q, 16'h000F);
        chk("abort mism_q", a.mism_q, 16'h000F);
        chk("abort err_cnt", a.err_cnt, 4);

        // async reset in the middle of a scan
        @(negedge clk);
        r_tab = 16'hFFFF;
        a.expected = 16'h0000;
        a.start = 1'b1;
        @(negedge clk);
        a.start = 1'b0;
        repeat (12) @(negedge clk);
        chk("pre-reset table_q", a.table_q, 16'h003F);
        #2 reset = 1'b1;
        #1;
        chk("async reset busy", a.busy, 0);
        chk("async reset fn_in", a.fn_in, 0);
        chk("async reset table_q", a.table_q, 0);
        chk("async reset mism_q", a.mism_q, 0);
        chk("async reset err_cnt", a.err_cnt, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("no resume busy", a.busy, 0);
        chk("no resume fn_in", a.fn_in, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
